// File: rtl/demux_3outputs_if.sv
// rtl/demux_3outputs_if.sv - handshake bundle for the 1-to-2 routing demux
interface demux_3outputs_if;
    logic [2:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [2:0] b_data;
    logic       b_valid;
    logic       b_ready;

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid
    );
endinterface

// File: rtl/demux_3outputs.sv
// rtl/demux_3outputs.sv - routes one input stream to two single-slot outputs with saturating delivery counters
module demux_3outputs #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    demux_3outputs_if.slave  bus,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);
    logic [2:0] a_data_q;
    logic [2:0] b_data_q;
    logic       a_valid_q;
    logic       b_valid_q;
    logic       a_free;
    logic       b_free;
    logic       a_load;
    logic       b_load;
    logic       a_out;
    logic       b_out;

    // A slot is free when empty or being drained this cycle, so each output sustains one word per cycle
    assign a_free = !a_valid_q || bus.a_ready;
    assign b_free = !b_valid_q || bus.b_ready;
    assign a_out  = a_valid_q && bus.a_ready;
    assign b_out  = b_valid_q && bus.b_ready;

    assign bus.in_ready = bus.in_sel ? b_free : a_free;
    assign a_load       = bus.in_valid && !bus.in_sel && a_free;
    assign b_load       = bus.in_valid &&  bus.in_sel && b_free;

    assign bus.a_data  = a_data_q;
    assign bus.a_valid = a_valid_q;
    assign bus.b_data  = b_data_q;
    assign bus.b_valid = b_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_data_q  <= 3'b000;
            a_valid_q <= 1'b0;
            a_count   <= '0;
        end else begin
            if (a_load) begin
                a_data_q <= bus.in_data;
            end
            if (a_load) begin
                a_valid_q <= 1'b1;
            end else if (a_out) begin
                a_valid_q <= 1'b0;
            end
            if (a_out && (a_count != {CNT_W{1'b1}})) begin
                a_count <= a_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_data_q  <= 3'b000;
            b_valid_q <= 1'b0;
            b_count   <= '0;
        end else begin
            if (b_load) begin
                b_data_q <= bus.in_data;
            end
            if (b_load) begin
                b_valid_q <= 1'b1;
            end else if (b_out) begin
                b_valid_q <= 1'b0;
            end
            if (b_out && (b_count != {CNT_W{1'b1}})) begin
                b_count <= b_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_demux_3outputs.sv
// tb/tb_demux_3outputs.sv - scoreboard bench for demux_3outputs
module tb_demux_3outputs;
    localparam int CNT_W = 8;
    localparam int MAXC  = 255;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    demux_3outputs_if bus ();

    demux_3outputs #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .a_count (a_count),
        .b_count (b_count)
    );

    int errors = 0;
    int checks = 0;
    logic [2:0] qa[$];
    logic [2:0] qb[$];
    int exp_a = 0;
    int exp_b = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: checks held words and counts mid-cycle, then books the transfers the next edge will perform
    always @(negedge clk) begin
        if (!reset) begin
            logic exp_rdy;
            check("a_valid", {31'd0, bus.a_valid}, {31'd0, qa.size() > 0});
            check("b_valid", {31'd0, bus.b_valid}, {31'd0, qb.size() > 0});
            if (qa.size() > 0) check("a_data", {29'd0, bus.a_data}, {29'd0, qa[0]});
            if (qb.size() > 0) check("b_data", {29'd0, bus.b_data}, {29'd0, qb[0]});
            check("a_count", {24'd0, a_count}, exp_a);
            check("b_count", {24'd0, b_count}, exp_b);
            exp_rdy = bus.in_sel ? (qb.size() == 0 || bus.b_ready) : (qa.size() == 0 || bus.a_ready);
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
            if (qa.size() > 0 && bus.a_ready) begin
                void'(qa.pop_front());
                if (exp_a < MAXC) exp_a++;
            end
            if (qb.size() > 0 && bus.b_ready) begin
                void'(qb.pop_front());
                if (exp_b < MAXC) exp_b++;
            end
            if (bus.in_valid && exp_rdy) begin
                if (bus.in_sel) qb.push_back(bus.in_data);
                else            qa.push_back(bus.in_data);
            end
        end
    end

    task automatic drive(input bit v, input bit s, input logic [2:0] d, input bit ar, input bit br);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
        bus.a_ready  = ar;
        bus.b_ready  = br;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 3'd0, 0, 0);
        reset = 1'b1;
        qa.delete();
        qb.delete();
        exp_a = 0;
        exp_b = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain();
        drive(0, 0, 3'd0, 1, 1);
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 3'd0, 0, 0);
        #12;
        check("rst_a_valid", {31'd0, bus.a_valid}, 0);
        check("rst_b_valid", {31'd0, bus.b_valid}, 0);
        check("rst_a_data",  {29'd0, bus.a_data}, 0);
        check("rst_b_data",  {29'd0, bus.b_data}, 0);
        check("rst_a_count", {24'd0, a_count}, 0);
        check("rst_b_count", {24'd0, b_count}, 0);
        step();
        reset = 1'b0;
        drive(0, 0, 3'd0, 0, 0);
        #1 check("rel_rdy_sel0", {31'd0, bus.in_ready}, 1);
        bus.in_sel = 1'b1;
        #1 check("rel_rdy_sel1", {31'd0, bus.in_ready}, 1);

        // Basic route and hold
        drive(1, 0, 3'b101, 0, 0);
        step();
        check("route_a_valid", {31'd0, bus.a_valid}, 1);
        check("route_a_data",  {29'd0, bus.a_data}, 5);
        check("route_b_valid", {31'd0, bus.b_valid}, 0);
        drive(0, 1, 3'b010, 0, 0);
        for (int i = 0; i < 3; i++) step();
        check("hold_a_data", {29'd0, bus.a_data}, 5);
        drive(0, 0, 3'd0, 1, 0);
        step();
        check("route_a_count", {24'd0, a_count}, 1);
        check("route_a_empty", {31'd0, bus.a_valid}, 0);

        // Backpressure on A while B accepts
        drive(1, 0, 3'd3, 0, 0);
        step();
        drive(1, 0, 3'd6, 0, 0);
        #1 check("bp_rdy_a", {31'd0, bus.in_ready}, 0);
        step();
        check("bp_a_data", {29'd0, bus.a_data}, 3);
        drive(1, 1, 3'd2, 0, 0);
        #1 check("bp_rdy_b", {31'd0, bus.in_ready}, 1);
        step();
        check("bp_b_data", {29'd0, bus.b_data}, 2);
        check("bp_a_keep", {29'd0, bus.a_data}, 3);
        drain();

        // Streaming 10 words into A
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 3'(i % 8), 1, 0);
            step();
        end
        drain();
        check("stream_a_count", {24'd0, a_count}, 10);

        // Alternating select
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 1'(i % 2), 3'($urandom_range(7)), 1, 1);
            step();
        end
        drain();
        check("alt_a_count", {24'd0, a_count}, 10);
        check("alt_b_count", {24'd0, b_count}, 10);

        // Saturation on B
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1, 1, 3'(i % 8), 1, 1);
            step();
        end
        drain();
        check("sat_b_count", {24'd0, b_count}, 255);
        check("sat_a_count", {24'd0, a_count}, 0);

        // Async reset with both slots full and nonzero counts
        drive(1, 0, 3'd7, 1, 1);
        step();
        drive(1, 1, 3'd6, 0, 0);
        step();
        drive(0, 0, 3'd0, 0, 0);
        #2;
        reset = 1'b1;
        qa.delete();
        qb.delete();
        exp_a = 0;
        exp_b = 0;
        #1;
        check("arst_a_valid", {31'd0, bus.a_valid}, 0);
        check("arst_b_valid", {31'd0, bus.b_valid}, 0);
        check("arst_a_data",  {29'd0, bus.a_data}, 0);
        check("arst_b_data",  {29'd0, bus.b_data}, 0);
        check("arst_a_count", {24'd0, a_count}, 0);
        check("arst_b_count", {24'd0, b_count}, 0);
        drive(0, 0, 3'd0, 1, 1);
        step();
        step();
        reset = 1'b0;
        drive(1, 1, 3'd4, 0, 0);
        #1 check("post_rdy", {31'd0, bus.in_ready}, 1);
        step();
        check("post_b_data", {29'd0, bus.b_data}, 4);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/demux_3outputs.md
DEMUX_3OUTPUTS -- requirements
Module: demux_3outputs

Interface
REQ-001 Parameter: CNT_W, 8, width of each per-output transfer counter.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: in_data  input  3  value to route.
REQ-005 Port: in_sel  input  1  destination select; 0 routes to output A, 1 routes to output B.
REQ-006 Port: in_valid  input  1  in_data/in_sel valid this cycle.
REQ-007 Port: in_ready  output  1  block accepts the input word this cycle.
REQ-008 Port: a_data  output  3  output A holding-register value.
REQ-009 Port: a_valid  output  1  output A holds an undelivered word.
REQ-010 Port: a_ready  input  1  output A sink accepts this cycle.
REQ-011 Port: b_data  output  3  output B holding-register value.
REQ-012 Port: b_valid  output  1  output B holds an undelivered word.
REQ-013 Port: b_ready  input  1  output B sink accepts this cycle.
REQ-014 Port: a_count  output  CNT_W  number of words delivered on A, saturating.
REQ-015 Port: b_count  output  CNT_W  number of words delivered on B, saturating.

Function
REQ-016 The block SHALL have exactly one holding register per output (data + valid); no other word storage.
REQ-017 Slot X (A or B) SHALL be "free" when x_valid=0 or (x_valid=1 and x_ready=1).
REQ-018 in_ready SHALL equal free(A) when in_sel=0 and free(B) when in_sel=1, combinationally; it SHALL NOT depend on in_valid.
REQ-019 An input transfer SHALL occur when in_valid=1 and in_ready=1; the selected slot SHALL load in_data and set valid on that edge (latency 1 cycle, input edge to x_valid=1).
REQ-020 An output transfer on X SHALL occur when x_valid=1 and x_ready=1; x_count SHALL increment by 1 on that edge.
REQ-021 Simultaneous output transfer on X and input transfer into X SHALL leave x_valid=1 with the new data (full throughput, one word/cycle per output).
REQ-022 Output transfer on X with no input transfer into X SHALL clear x_valid on that edge; x_data MAY retain its old value.
REQ-023 While x_valid=1 and x_ready=0, x_data and x_valid SHALL hold stable.
REQ-024 The unselected slot SHALL be unaffected by the input transfer; A and B drain independently and concurrently.
REQ-025 x_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 x_ready asserted while x_valid=0 SHALL have no effect.
REQ-027 in_data/in_sel SHALL be ignored when in_valid=0.

Reset
REQ-028 While reset=1, a_valid, b_valid SHALL be 0, a_data, b_data SHALL be 3'b000, a_count, b_count SHALL be 0, asynchronously, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard any held word; no output transfer counts for the edge where reset is high.
REQ-030 After reset release, the first rising edge SHALL be able to accept an input transfer (in_ready=1 for either sel).

Verification
REQ-031 Basic route: in_data=3'b101, sel=0, valid=1 one cycle, a_ready=0 -> next cycle a_valid=1, a_data=101, b_valid=0; stays held until a_ready=1, then a_count=1.
REQ-032 Backpressure: A held with a_ready=0, present sel=0 word -> in_ready=0, a_data unchanged; present sel=1 word same cycle -> in_ready=1, b_data loads next edge.
REQ-033 Streaming: a_ready=1, sel=0, valid=1 for 10 cycles with data 0..7,0,1 -> a_valid continuous from cycle 1, data sequence matches, a_count=10.
REQ-034 Saturation: deliver 300 words on B with CNT_W=8 -> b_count=255, a_count=0.
REQ-035 Async reset: assert reset between clock edges while a_valid=b_valid=1 -> all valids, data and counts 0 immediately, before next edge.
REQ-036 Alternating sel 0/1 every cycle, both readys=1 -> each output delivers every other word in order, a_count=b_count after even count of inputs.
